// File: rtl/aes_uart_pkg.sv
// -----------------------------------------------------------------------------
// aes_uart_pkg
// Shared constants for the AES-over-UART datapath. The UART side moves bytes,
// the AES core consumes 128-bit blocks; every block-boundary module takes its
// default widths from here so the two sides stay consistent.
// -----------------------------------------------------------------------------
package aes_uart_pkg;

    localparam int BYTE_W          = 8;
    localparam int BLOCK_W         = 128;
    localparam int BYTES_PER_BLOCK = BLOCK_W / BYTE_W;

endpackage : aes_uart_pkg

// File: rtl/sipo_128.sv
// -----------------------------------------------------------------------------
// sipo_128
// Word-serial to block-parallel assembler on the UART receive path. One
// IN_W-bit word is captured on every rising edge (no valid qualifier). After
// NUM_WORDS = OUT_W/IN_W words the assembled block is loaded into
// parallel_out and full strobes for one cycle. The first word of a block lands
// in the MSBs, the last word in the LSBs. Blocks follow back to back with no
// idle cycle.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset (0 = reset)
//   serial_in    in   [IN_W-1:0]  word sampled every edge out of reset
//   parallel_out out  [OUT_W-1:0] last completed block, stable between strobes
//   full         out  one-cycle strobe: parallel_out was just loaded
//
// No backpressure: the consumer must take parallel_out within NUM_WORDS
// cycles of the strobe, before the next block overwrites it.
// -----------------------------------------------------------------------------
module sipo_128
    import aes_uart_pkg::*;
#(
    parameter int IN_W  = BYTE_W,
    parameter int OUT_W = BLOCK_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  serial_in,
    output logic [OUT_W-1:0] parallel_out,
    output logic             full
);

    localparam int NUM_WORDS = OUT_W / IN_W;
    // Keep the counter at least one bit wide so a single-word block still
    // elaborates cleanly.
    localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    // A block must be a whole number of words.
    generate
        if ((OUT_W % IN_W) != 0) begin : g_bad_width
            $error("sipo_128: OUT_W (%0d) must be a multiple of IN_W (%0d)", OUT_W, IN_W);
        end
    endgenerate

    logic [OUT_W-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic [OUT_W-1:0] next_block;
    logic             last_word;

    // Shift register contents after this edge's word is appended. The
    // degenerate single-word case has no older words to keep.
    generate
        if (OUT_W == IN_W) begin : g_one_word
            assign next_block = serial_in;
        end else begin : g_multi_word
            assign next_block = {shreg[OUT_W-IN_W-1:0], serial_in};
        end
    endgenerate

    assign last_word = (cnt == LAST_IDX);

    // NOTE: state registers use non-blocking assignments so every register in
    // this block samples pre-edge values; blocking here would let parallel_out
    // see an already-shifted shreg.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the wide shift register is reset too, not just the
            // counter: a partial block must never leak into a later block.
            shreg        <= '0;
            cnt          <= '0;
            parallel_out <= '0;
            full         <= 1'b0;
        end else begin
            shreg <= next_block;
            if (last_word) begin
                // Capture includes the word arriving on this very edge.
                parallel_out <= next_block;
                full         <= 1'b1;
                cnt          <= '0;
            end else begin
                full <= 1'b0;
                cnt  <= cnt + CNT_W'(1);
            end
        end
    end

endmodule : sipo_128

// File: tb/tb_sipo_128.sv
// -----------------------------------------------------------------------------
// tb_sipo_128
// Self-checking bench for sipo_128. Every driven byte goes into a reference
// block; when 16 bytes are complete the block is pushed onto a scoreboard
// queue, and on the falling edge after the capturing edge the bench expects
// full = 1 and pops the block to compare against parallel_out.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sipo_128;

    localparam int IN_W  = 8;
    localparam int OUT_W = 128;
    localparam int NW    = OUT_W / IN_W;

    logic             clk;
    logic             reset;
    logic [IN_W-1:0]  serial_in;
    logic [OUT_W-1:0] parallel_out;
    logic             full;

    sipo_128 #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .parallel_out (parallel_out),
        .full         (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [OUT_W-1:0] ref_block;
    int               ref_cnt;
    logic [OUT_W-1:0] sb_q[$];
    logic [OUT_W-1:0] held;
    int               cyc;
    int               last_full_cyc;
    int               full_pulses;
    int               blocks_pushed;

    task automatic check(input string tag, input logic [OUT_W-1:0] obs,
                         input logic [OUT_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_ref();
        ref_block     = '0;
        ref_cnt       = 0;
        held          = '0;
        last_full_cyc = -1;
        sb_q.delete();
    endtask

    // Present one byte, let the DUT capture it, then check outputs on the
    // following falling edge.
    task automatic drive(input logic [IN_W-1:0] b);
        logic             pushed;
        logic [OUT_W-1:0] exp_blk;
        serial_in = b;
        @(posedge clk);
        cyc++;
        ref_block = {ref_block[OUT_W-IN_W-1:0], b};
        ref_cnt++;
        pushed = 1'b0;
        if (ref_cnt == NW) begin
            sb_q.push_back(ref_block);
            blocks_pushed++;
            ref_cnt = 0;
            pushed  = 1'b1;
        end
        @(negedge clk);
        check("full_strobe", {127'd0, full}, {127'd0, pushed});
        if (full) begin
            full_pulses++;
            if (sb_q.size() == 0) begin
                check("unexpected_full", 128'd1, 128'd0);
            end else begin
                exp_blk = sb_q.pop_front();
                check("block", parallel_out, exp_blk);
                held = exp_blk;
            end
            if (last_full_cyc >= 0)
                check("full_gap", OUT_W'(cyc - last_full_cyc), OUT_W'(NW));
            last_full_cyc = cyc;
        end else begin
            check("hold", parallel_out, held);
        end
    endtask

    // Async reset asserted mid-cycle; outputs must clear before any edge.
    task automatic async_reset_pulse(input string tag);
        #2 reset = 1'b0;
        clear_ref();
        #1;
        check({tag, "_po"}, parallel_out, '0);
        check({tag, "_full"}, {127'd0, full}, 128'd0);
        #1 reset = 1'b1;
    endtask

    initial begin
        logic [OUT_W-1:0] blk;
        logic [IN_W-1:0]  v;
        serial_in     = '0;
        reset         = 1'b0;
        cyc           = 0;
        full_pulses   = 0;
        blocks_pushed = 0;
        clear_ref();

        // Reset held for two cycles
        repeat (2) @(negedge clk);
        check("rst_po", parallel_out, '0);
        check("rst_full", {127'd0, full}, 128'd0);
        reset = 1'b1;

        // Single block with a fixed pattern
        begin
            logic [7:0] pat [16] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF,
                                     8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};
            for (int i = 0; i < 16; i++) drive(pat[i]);
        end
        check("single_lit", parallel_out, 128'h0123456789ABCDEFFEDCBA9876543210);
        check("single_full", {127'd0, full}, 128'd1);

        // Hold: 15 zeros keep the block, 16th loads an all-zero block
        for (int i = 0; i < 15; i++) drive(8'h00);
        check("hold_lit", parallel_out, 128'h0123456789ABCDEFFEDCBA9876543210);
        check("hold_full", {127'd0, full}, 128'd0);
        drive(8'h00);
        check("zero_lit", parallel_out, 128'd0);
        check("zero_full", {127'd0, full}, 128'd1);

        // Back-to-back blocks
        for (int i = 0; i < 16; i++) drive(8'(i));
        check("b2b_lit0", parallel_out, 128'h000102030405060708090A0B0C0D0E0F);
        for (int i = 16; i < 32; i++) drive(8'(i));
        check("b2b_lit1", parallel_out, 128'h101112131415161718191A1B1C1D1E1F);

        // Async reset from a loaded, non-zero state
        async_reset_pulse("async_rst");

        // Reset mid-block: 7 bytes discarded
        for (int i = 0; i < 7; i++) drive(8'hC0 + 8'(i));
        async_reset_pulse("mid_rst");
        for (int i = 0; i < 16; i++) drive(8'hAA + 8'(i));
        check("mid_lit", parallel_out, 128'hAAABACADAEAFB0B1B2B3B4B5B6B7B8B9);

        // 100 random blocks streamed without a gap
        for (int b = 0; b < 100; b++) begin
            for (int i = 0; i < NW; i++) begin
                v = 8'($urandom_range(0, 255));
                drive(v);
            end
        end

        check("sb_empty", OUT_W'(sb_q.size()), '0);
        check("pulse_count", OUT_W'(full_pulses), OUT_W'(blocks_pushed));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_sipo_128
